// File: rtl/tree_walker.sv
// Decision-tree traversal engine: walks one tree ROM from the root to a leaf per feature vector.
// Optional macro TREE_WALKER_NODE_ID_CHECK_EN enables a node_id vs. rom_addr consistency check.
module tree_walker #(
   parameter int NODE_WIDTH = 120,
   parameter int ADDR_WIDTH = 10,
   parameter int N_FEATURES = 16,
   parameter int MAX_DEPTH  = 32,
   parameter int ROOT_ADDR  = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_FEATURES*32-1:0] features,
   output logic [ADDR_WIDTH-1:0]   rom_addr,
   input  logic [NODE_WIDTH-1:0]   rom_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [3:0]              out_class,
   output logic                    out_error,
   output logic                    busy
);

   localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
   localparam logic [DEPTH_W-1:0]    DEPTH_LIMIT = DEPTH_W'(MAX_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ROOT        = ADDR_WIDTH'(ROOT_ADDR);
   localparam logic [3:0]            KIND_LEAF   = 4'h3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_EVAL,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
   logic [DEPTH_W-1:0]      depth_q, depth_d;
   logic [3:0]              class_q, class_d;
   logic                    error_q, error_d;
   logic [N_FEATURES*32-1:0] feat_q;

   logic [3:0]              node_kind;
   logic [31:0]             node_thr;
   logic [ADDR_WIDTH-1:0]   node_left;
   logic [ADDR_WIDTH-1:0]   node_right;
   logic [3:0]              node_class;
   logic [31:0]             feat_sel [16];
   logic [31:0]             feat_val;
   logic                    kind_oob;
   logic                    go_left;
   logic                    unused_bits;

   // Maps IEEE-754 single to a key whose unsigned order matches the float order (-0.0 < +0.0).
   function automatic logic [31:0] order_key(input logic [31:0] x);
      return x[31] ? ~x : (x ^ 32'h8000_0000);
   endfunction

   function automatic logic float_le(input logic [31:0] a, input logic [31:0] b);
      return order_key(a) <= order_key(b);
   endfunction

   assign node_kind  = rom_data[95:92];
   assign node_thr   = rom_data[91:60];
   assign node_left  = rom_data[16 +: ADDR_WIDTH];
   assign node_right = rom_data[4 +: ADDR_WIDTH];
   assign node_class = rom_data[3:0];

   assign unused_bits = ^{rom_data[NODE_WIDTH-1:96], rom_data[59:28],
                          rom_data[27:16], rom_data[15:4]};

`ifdef TREE_WALKER_NODE_ID_CHECK_EN
   logic [ADDR_WIDTH-1:0] node_id;
   assign node_id = rom_data[96 +: ADDR_WIDTH];
`endif

   // The 4-bit kind field can name up to 16 features; slots past N_FEATURES read as zero.
   for (genvar k = 0; k < 16; k++) begin : g_feat
      if (k < N_FEATURES) begin : g_real
         assign feat_sel[k] = feat_q[k*32 +: 32];
      end else begin : g_pad
         assign feat_sel[k] = '0;
      end
   end

   assign feat_val = feat_sel[node_kind];
   assign kind_oob = {28'd0, node_kind} >= 32'(N_FEATURES);
   assign go_left  = float_le(feat_val, node_thr);

   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      depth_d    = depth_q;
      class_d    = class_q;
      error_d    = error_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               rom_addr_d = ROOT;
               depth_d    = '0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            state_d = S_EVAL;
         end
         S_EVAL: begin
            state_d = S_DONE;
`ifdef TREE_WALKER_NODE_ID_CHECK_EN
            if (node_id != rom_addr_q) begin
               class_d = 4'd0;
               error_d = 1'b1;
            end else
`endif
            if (node_kind == KIND_LEAF) begin
               class_d = node_class;
               error_d = 1'b0;
            end else if (kind_oob || (depth_q == DEPTH_LIMIT)) begin
               class_d = 4'd0;
               error_d = 1'b1;
            end else begin
               rom_addr_d = go_left ? node_left : node_right;
               depth_d    = depth_q + 1'b1;
               state_d    = S_WAIT;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rom_addr_q <= ROOT;
         depth_q    <= '0;
         class_q    <= 4'd0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         depth_q    <= depth_d;
         class_q    <= class_d;
         error_q    <= error_d;
      end
   end

   // Feature latch is pure data and is only written on accept.
   always_ff @(posedge clk) begin
      if ((state_q == S_IDLE) && in_valid) begin
         feat_q <= features;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_class = class_q;
   assign out_error = error_q;
   assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_tree_walker.sv
// Self-checking bench for tree_walker: directed cases plus random ROMs against a tree-walking model.
module tb_tree_walker;
   localparam int NW = 120;
   localparam int AW = 10;
   localparam int NF = 16;
   localparam int MD = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [NF*32-1:0] features;
   logic [AW-1:0]   rom_addr;
   logic [NW-1:0]   rom_data;
   logic            out_valid;
   logic            out_ready;
   logic [3:0]      out_class;
   logic            out_error;
   logic            busy;

   logic [NW-1:0]   rom_mem [1024];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   tree_walker #(
      .NODE_WIDTH(NW), .ADDR_WIDTH(AW), .N_FEATURES(NF), .MAX_DEPTH(MD), .ROOT_ADDR(0)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .features(features),
      .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_error(out_error), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NW-1:0] mk_node(input logic [AW-1:0] id, input logic [3:0] kind,
                                             input logic [31:0] thr, input logic [11:0] l,
                                             input logic [11:0] r, input logic [3:0] cls);
      logic [NW-1:0] n;
      n = '0;
      n[119:108] = 12'($urandom);
      n[107:96]  = {2'b00, id};
      n[95:92]   = kind;
      n[91:60]   = thr;
      n[59:28]   = $urandom;
      n[27:16]   = l;
      n[15:4]    = r;
      n[3:0]     = cls;
      return n;
   endfunction

   // Float "a <= b" by sign/magnitude reasoning: any negative (incl. -0) is below any positive.
   function automatic bit float_le(input logic [31:0] a, input logic [31:0] b);
      if (a[31] != b[31]) return a[31];
      if (!a[31]) return a[30:0] <= b[30:0];
      return a[30:0] >= b[30:0];
   endfunction

   task automatic model(input logic [NF*32-1:0] f, output logic [3:0] cls,
                        output logic err, output int evals);
      int addr, depth;
      bit done;
      logic [NW-1:0] node;
      logic [3:0] kind;
      addr = 0; depth = 0; evals = 0; cls = 4'd0; err = 1'b0; done = 1'b0;
      for (int step = 0; step < 200 && !done; step++) begin
         node = rom_mem[addr];
         kind = node[95:92];
         evals++;
         done = 1'b1;
`ifdef TREE_WALKER_NODE_ID_CHECK_EN
         if (int'(node[96 +: AW]) != addr) begin
            err = 1'b1; cls = 4'd0;
         end else
`endif
         if (kind == 4'h3) begin
            cls = node[3:0]; err = 1'b0;
         end else if (int'(kind) >= NF || depth == MD) begin
            cls = 4'd0; err = 1'b1;
         end else begin
            addr  = float_le(f[int'(kind)*32 +: 32], node[91:60]) ? int'(node[16 +: AW])
                                                                : int'(node[4 +: AW]);
            depth = depth + 1;
            done  = 1'b0;
         end
      end
   endtask

   task automatic start_and_wait(input logic [NF*32-1:0] f, input string tag,
                                 output logic [3:0] ecls, output int cyc);
      logic eerr;
      int evals;
      model(f, ecls, eerr, evals);
      @(negedge clk);
      features = f;
      in_valid = 1'b1;
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         @(posedge clk);
         #1 cyc++;
      end
      check({tag, " latency"}, cyc, 2 * evals);
      check({tag, " class"}, 32'(out_class), 32'(ecls));
      check({tag, " error"}, 32'(out_error), 32'(eerr));
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, " post out_valid"}, 32'(out_valid), 32'd0);
      check({tag, " post in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic do_req(input logic [NF*32-1:0] f, input string tag);
      logic [3:0] c;
      int cyc;
      start_and_wait(f, tag, c, cyc);
      release_out(tag);
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] sp [8];
      sp = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
             32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h4060_0000};
      if ($urandom_range(0, 2) == 0) return sp[$urandom_range(0, 7)];
      return $urandom;
   endfunction

   task automatic load3(input logic [31:0] thr);
      rom_mem[0] = mk_node(10'd0, 4'd0, thr, 12'd1, 12'd2, 4'd9);
      rom_mem[1] = mk_node(10'd1, 4'h3, 32'($urandom), 12'($urandom), 12'($urandom), 4'd1);
      rom_mem[2] = mk_node(10'd2, 4'h3, 32'($urandom), 12'($urandom), 12'($urandom), 4'd0);
   endtask

   function automatic logic [NF*32-1:0] fv0(input logic [31:0] f0);
      logic [NF*32-1:0] v;
      v = '0;
      for (int k = 0; k < NF; k++) v[k*32 +: 32] = $urandom;
      v[31:0] = f0;
      return v;
   endfunction

   initial begin
      logic [3:0] ecls;
      int cyc;
      logic [NF*32-1:0] fv;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; features = '0;
      for (int a = 0; a < 1024; a++) rom_mem[a] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset rom_addr", 32'(rom_addr), 32'd0);
      check("reset out_class", 32'(out_class), 32'd0);
      check("reset out_error", 32'(out_error), 32'd0);

      // three-node tree, threshold 3.5
      load3(32'h4060_0000);
      start_and_wait(fv0(32'h3F80_0000), "f0=1.0", ecls, cyc);
      check("f0=1.0 lat4", cyc, 4);
      check("f0=1.0 class1", 32'(out_class), 32'd1);
      release_out("f0=1.0");
      do_req(fv0(32'h4060_0000), "f0=3.5 eq");
      do_req(fv0(32'h4080_0000), "f0=4.0");

      load3(32'h0000_0000);
      do_req(fv0(32'h8000_0000), "-0 vs +0");
      do_req(fv0(32'h0000_0000), "+0 vs +0");
      load3(32'h8000_0000);
      do_req(fv0(32'h0000_0000), "+0 vs -0");
      load3(32'hBF80_0000);
      do_req(fv0(32'hC000_0000), "-2 vs -1");
      do_req(fv0(32'hBF00_0000), "-0.5 vs -1");

      // self-loop hits the depth limit
      rom_mem[0] = mk_node(10'd0, 4'd0, 32'h4060_0000, 12'd0, 12'd0, 4'd7);
      start_and_wait(fv0(32'h3F80_0000), "selfloop", ecls, cyc);
      check("selfloop lat66", cyc, 66);
      check("selfloop err", 32'(out_error), 32'd1);
      check("selfloop class", 32'(out_class), 32'd0);
      release_out("selfloop");

      // backpressure: result held, new request ignored while DONE
      load3(32'h4060_0000);
      start_and_wait(fv0(32'h3F80_0000), "bp", ecls, cyc);
      @(negedge clk);
      in_valid = 1'b1;
      features = fv0(32'h4080_0000);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp out_valid", 32'(out_valid), 32'd1);
         check("bp out_class", 32'(out_class), 32'(ecls));
         check("bp in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("bp release busy", 32'(busy), 32'd0);
      check("bp release in_ready", 32'(in_ready), 32'd1);

      // asynchronous reset during the second WAIT
      @(negedge clk);
      features = fv0(32'h3F80_0000);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst rom_addr", 32'(rom_addr), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst out_class", 32'(out_class), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("midrst in_ready", 32'(in_ready), 32'd1);
      do_req(fv0(32'h4080_0000), "after rst");
      do_req(fv0(32'h3F80_0000), "after rst 2");

      // node_id mismatch at addr2 (only flagged when the check is built in)
      rom_mem[2] = mk_node(10'd5, 4'h3, 32'd0, 12'd0, 12'd0, 4'd6);
      start_and_wait(fv0(32'h4080_0000), "id mismatch", ecls, cyc);
`ifdef TREE_WALKER_NODE_ID_CHECK_EN
      check("id mismatch err", 32'(out_error), 32'd1);
`else
      check("id ignored class", 32'(out_class), 32'd6);
`endif
      release_out("id mismatch");

      // random graph ROMs (loops allowed, leaves ~30%)
      for (int t = 0; t < 3; t++) begin
         for (int a = 0; a < 64; a++) begin
            logic [3:0] k;
            k = ($urandom_range(0, 9) < 3) ? 4'h3 : 4'($urandom_range(0, 15));
            rom_mem[a] = mk_node(AW'(a), k, rand_word(),
                                 12'($urandom_range(0, 63)) | (12'($urandom_range(0, 3)) << 10),
                                 12'($urandom_range(0, 63)) | (12'($urandom_range(0, 3)) << 10),
                                 4'($urandom));
         end
         for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < NF; k++) fv[k*32 +: 32] = rand_word();
            do_req(fv, "random");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/tree_walker.md
Name: tree_walker

Overview:
- Traversal engine that reads one decision tree from a tree ROM and classifies one feature vector per request.
- Drives the ROM address and consumes the ROM's 1-cycle registered node word.
- Walks from the root to a leaf, then returns the leaf's class label over a valid/ready handshake.
- One instance per tree ROM; a downstream voter collects the outputs.

Parameters:
- NODE_WIDTH, 120, width of the ROM node word.
- ADDR_WIDTH, 10, width of the ROM address.
- N_FEATURES, 16, number of 32-bit features in the input vector.
- MAX_DEPTH, 32, maximum number of internal nodes visited before abort.
- ROOT_ADDR, 0, address of the root node.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  feature vector valid
- in_ready  out  1  engine can accept a vector
- features  in  N_FEATURES*32  IEEE-754 single features; feature k = features[32k+31:32k]
- rom_addr  out  ADDR_WIDTH  node address to ROM (registered)
- rom_data  in  NODE_WIDTH  node word; valid the cycle after the ROM samples rom_addr
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_class  out  4  leaf class label
- out_error  out  1  traversal aborted; out_class = 0
- busy  out  1  high in any state except IDLE

Behaviour:
- Node word fields:
  - [119:108] ignored
  - [107:96] node_id
  - [95:92] kind: 4'h3 = leaf, any other value = internal node with feature index = kind
  - [91:60] threshold (IEEE-754 single)
  - [59:28] ignored
  - [27:16] left child
  - [15:4] right child
  - [3:0] class (meaningful for leaves only)
- Child address = low ADDR_WIDTH bits of the child field.
- FSM states: IDLE, WAIT, EVAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch features, rom_addr<=ROOT_ADDR, depth<=0, go to WAIT.
- WAIT: one cycle for the ROM read; go to EVAL.
- EVAL (uses rom_data):
  - Leaf: out_class<=class, out_error<=0, go to DONE.
  - Internal node, feature index >= N_FEATURES or depth == MAX_DEPTH: out_error<=1, out_class<=0, go to DONE.
  - Otherwise compare and go left if feature <= threshold, else right. rom_addr<=child, depth<=depth+1, go to WAIT.
- Compare rule:
  - Map each 32-bit value x to key = x[31] ? ~x : x ^ 32'h80000000, then compare keys unsigned.
  - Consequence: -0.0 < +0.0.
  - NaNs order by key (no special case).
- DONE:
  - out_valid=1.
  - out_valid, out_class and out_error are held stable until out_ready.
  - On out_ready, go to IDLE.
  - A new in_valid is not accepted in the same cycle as out_ready; in_ready=0 outside IDLE.
- Latency: accept edge to out_valid = 2*(D+1) cycles, where D = number of internal nodes visited. A root leaf gives 2 cycles.
- rom_addr holds its last value outside traversal.
- Reset (asynchronous, any state, including mid-walk): state=IDLE, rom_addr=ROOT_ADDR, out_valid=0, out_class=0, out_error=0, depth=0, busy=0, in_ready=1 after reset deasserts. The feature latch is not required to clear.

Optional Feature:
- Macro: TREE_WALKER_NODE_ID_CHECK_EN.
- When defined: in EVAL, if node_id[ADDR_WIDTH-1:0] != the address currently on rom_addr, set out_error=1, out_class=0 and go to DONE. This check takes priority over the leaf and internal decode.
- When undefined: node_id is ignored and no extra logic is built.

Test Plan:
- Three-node ROM:
  - addr0 = internal, feature 0, threshold 0x40600000 (3.5), left=1, right=2.
  - addr1 = leaf, class 1.
  - addr2 = leaf, class 0.
- Three-node ROM, f0=0x3F800000 (1.0) -> out_valid 4 cycles after accept, out_class=1, out_error=0.
- Three-node ROM, f0=0x40600000 (3.5, equal to threshold) -> goes left, out_class=1. f0=0x40800000 (4.0) -> out_class=0.
- Three-node ROM, f0=0x80000000 (-0.0) with threshold 0x00000000 -> left. f0=0xC0000000 (-2.0) with threshold 0xBF800000 (-1.0) -> left.
- Self-loop ROM (addr0 internal, left=right=0), MAX_DEPTH=32 -> out_error=1, out_class=0, out_valid at cycle 66.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid/out_class stable, in_ready=0. Assert out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-walk: pulse rst during the second WAIT -> out_valid=0, rom_addr=0, busy=0 immediately. The next request classifies correctly. With the macro defined, a node_id mismatch at addr2 -> out_error=1.
